// File: rtl/pseudo_axi_splitter_pkg.sv
`default_nettype none
// ============================================================================
// pseudo_axi_pkg : shared command type and direction encodings
// Rev 1.0
// ============================================================================
package pseudo_axi_pkg;

   typedef struct packed {
      logic [7:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [1:0]  lock;
   } paxi_cmd_t;

   localparam logic ATYPE_READ  = 1'b0;
   localparam logic ATYPE_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/paxi_cmd_fifo.sv
`default_nettype none
// ============================================================================
// paxi_cmd_fifo : register-based command FIFO with registered valid/occupancy
// Rev 1.0
// ============================================================================
module paxi_cmd_fifo
   import pseudo_axi_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push_valid_i,
   output logic      push_ready_o,
   input  paxi_cmd_t push_data_i,
   output logic      pop_valid_o,
   input  logic      pop_ready_i,
   output paxi_cmd_t pop_data_o,
   output logic      empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   paxi_cmd_t         mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic              valid_q;
   logic              w_push, w_pop;

   assign push_ready_o = (count_q < CW'(DEPTH));
   // Output valid is masked during reset so it drops in the reset cycle itself.
   assign pop_valid_o  = valid_q & ~reset;
   assign pop_data_o   = mem_q[rd_ptr_q];
   assign empty_o      = (count_q == '0);

   assign w_push = push_valid_i & push_ready_o;
   assign w_pop  = pop_valid_o & pop_ready_i;

   always_comb begin
      count_d = count_q;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (w_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
         valid_q <= (count_d != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule
`default_nettype wire

// File: rtl/pseudo_axi_splitter.sv
`default_nettype none
// ============================================================================
// pseudo_axi_splitter : splits a combined pseudo-AXI command stream into AR/AW
// Rev 1.0
// ============================================================================
module pseudo_axi_splitter
   import pseudo_axi_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  paxi_aid,
   input  logic [31:0] paxi_aaddr,
   input  logic [7:0]  paxi_alen,
   input  logic [2:0]  paxi_asize,
   input  logic [1:0]  paxi_aburst,
   input  logic [1:0]  paxi_alock,
   input  logic        paxi_atype,
   input  logic        paxi_avalid,
   output logic        paxi_aready,
   output logic [7:0]  axi_arid,
   output logic [31:0] axi_araddr,
   output logic [7:0]  axi_arlen,
   output logic [2:0]  axi_arsize,
   output logic [1:0]  axi_arburst,
   output logic [1:0]  axi_arlock,
   output logic        axi_arvalid,
   input  logic        axi_arready,
   output logic [7:0]  axi_awid,
   output logic [31:0] axi_awaddr,
   output logic [7:0]  axi_awlen,
   output logic [2:0]  axi_awsize,
   output logic [1:0]  axi_awburst,
   output logic [1:0]  axi_awlock,
   output logic        axi_awvalid,
   input  logic        axi_awready,
   output logic        idle
);

   logic      hold_valid_q, hold_valid_d;
   logic      hold_type_q;
   paxi_cmd_t hold_cmd_q;
   paxi_cmd_t w_in_cmd, w_ar_head, w_aw_head;
   logic      w_ar_push, w_aw_push, w_ar_room, w_aw_room;
   logic      w_ar_empty, w_aw_empty, w_drain, w_accept;

   assign w_in_cmd = '{id: paxi_aid, addr: paxi_aaddr, len: paxi_alen,
                       size: paxi_asize, burst: paxi_aburst, lock: paxi_alock};

   assign w_ar_push = hold_valid_q & (hold_type_q == ATYPE_READ);
   assign w_aw_push = hold_valid_q & (hold_type_q == ATYPE_WRITE);
   assign w_drain   = (w_ar_push & w_ar_room) | (w_aw_push & w_aw_room);

   // Built only from hold state and registered FIFO occupancy: no paxi_* input path.
   assign paxi_aready = (~hold_valid_q | w_drain) & ~reset;
   assign w_accept    = paxi_avalid & paxi_aready;
   assign idle        = reset | (~hold_valid_q & w_ar_empty & w_aw_empty);

   always_comb begin
      hold_valid_d = hold_valid_q;
      if (w_accept)     hold_valid_d = 1'b1;
      else if (w_drain) hold_valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_valid_q <= 1'b0;
         hold_type_q  <= ATYPE_READ;
         hold_cmd_q   <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         if (w_accept) begin
            hold_type_q <= paxi_atype;
            hold_cmd_q  <= w_in_cmd;
         end
      end
   end

   paxi_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_ar_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_valid_i (w_ar_push),
      .push_ready_o (w_ar_room),
      .push_data_i  (hold_cmd_q),
      .pop_valid_o  (axi_arvalid),
      .pop_ready_i  (axi_arready),
      .pop_data_o   (w_ar_head),
      .empty_o      (w_ar_empty)
   );

   paxi_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_aw_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_valid_i (w_aw_push),
      .push_ready_o (w_aw_room),
      .push_data_i  (hold_cmd_q),
      .pop_valid_o  (axi_awvalid),
      .pop_ready_i  (axi_awready),
      .pop_data_o   (w_aw_head),
      .empty_o      (w_aw_empty)
   );

   assign axi_arid    = w_ar_head.id;
   assign axi_araddr  = w_ar_head.addr;
   assign axi_arlen   = w_ar_head.len;
   assign axi_arsize  = w_ar_head.size;
   assign axi_arburst = w_ar_head.burst;
   assign axi_arlock  = w_ar_head.lock;

   assign axi_awid    = w_aw_head.id;
   assign axi_awaddr  = w_aw_head.addr;
   assign axi_awlen   = w_aw_head.len;
   assign axi_awsize  = w_aw_head.size;
   assign axi_awburst = w_aw_head.burst;
   assign axi_awlock  = w_aw_head.lock;

endmodule
`default_nettype wire

// File: tb/tb_pseudo_axi_splitter.sv
`default_nettype none
// ============================================================================
// tb_pseudo_axi_splitter : directed, table-driven bench for pseudo_axi_splitter
// Rev 1.0
// ============================================================================
module tb_pseudo_axi_splitter;
   import pseudo_axi_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  paxi_aid;
   logic [31:0] paxi_aaddr;
   logic [7:0]  paxi_alen;
   logic [2:0]  paxi_asize;
   logic [1:0]  paxi_aburst, paxi_alock;
   logic        paxi_atype, paxi_avalid, paxi_aready;
   logic [7:0]  axi_arid, axi_awid;
   logic [31:0] axi_araddr, axi_awaddr;
   logic [7:0]  axi_arlen, axi_awlen;
   logic [2:0]  axi_arsize, axi_awsize;
   logic [1:0]  axi_arburst, axi_arlock, axi_awburst, axi_awlock;
   logic        axi_arvalid, axi_arready, axi_awvalid, axi_awready, idle;

   pseudo_axi_splitter #(.FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .paxi_aid(paxi_aid), .paxi_aaddr(paxi_aaddr), .paxi_alen(paxi_alen),
      .paxi_asize(paxi_asize), .paxi_aburst(paxi_aburst), .paxi_alock(paxi_alock),
      .paxi_atype(paxi_atype), .paxi_avalid(paxi_avalid), .paxi_aready(paxi_aready),
      .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
      .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
      .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .idle(idle)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic      atype;
      paxi_cmd_t cmd;
      logic      exp_aready;
   } vec_t;

   int        n_checks = 0;
   int        n_fail   = 0;
   int        ar_xfers = 0;
   int        aw_xfers = 0;
   paxi_cmd_t exp_ar[$];
   paxi_cmd_t exp_aw[$];
   vec_t      tbl[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Transfers happen on the next rising edge; inputs only change just after rising edges.
   always @(negedge clk) begin
      if (axi_arvalid && axi_arready) begin
         ar_xfers++;
         if (exp_ar.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
         else chk("ar_fields", {axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock},
                  64'(exp_ar.pop_front()));
      end
      if (axi_awvalid && axi_awready) begin
         aw_xfers++;
         if (exp_aw.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
         else chk("aw_fields", {axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock},
                  64'(exp_aw.pop_front()));
      end
   end

   task automatic send(input logic t, input paxi_cmd_t c, output logic first_ready);
      logic got;
      got = 1'b0;
      first_ready = 1'b0;
      if (t == ATYPE_READ) exp_ar.push_back(c); else exp_aw.push_back(c);
      paxi_atype  = t;
      paxi_aid    = c.id;    paxi_aaddr  = c.addr;  paxi_alen  = c.len;
      paxi_asize  = c.size;  paxi_aburst = c.burst; paxi_alock = c.lock;
      paxi_avalid = 1'b1;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         got = paxi_aready;
         if (k == 0) first_ready = paxi_aready;
         @(posedge clk); #1;
      end
      if (!got) chk("send_timeout", 64'd0, 64'd1);
      paxi_avalid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      logic done;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         done = idle && !paxi_avalid && exp_ar.size() == 0 && exp_aw.size() == 0;
      end
      chk(name, 64'(done), 64'd1);
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
      end
   endtask

   function automatic paxi_cmd_t mk(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
      paxi_cmd_t c;
      c.id = id; c.addr = addr; c.len = len; c.size = 3'd3; c.burst = 2'd1; c.lock = 2'd0;
      return c;
   endfunction

   initial begin
      logic      fr;
      int        ar0, aw0;
      paxi_cmd_t r1;

      for (int i = 0; i < 16; i++) begin
         tbl[i].atype      = (i % 2 == 0) ? ATYPE_READ : ATYPE_WRITE;
         tbl[i].cmd.id     = 8'(8'h20 + i);
         tbl[i].cmd.addr   = 32'hA000_0000 | (32'(i) << 6);
         tbl[i].cmd.len    = 8'(i * 3);
         tbl[i].cmd.size   = 3'(i % 8);
         tbl[i].cmd.burst  = 2'(i % 3);
         tbl[i].cmd.lock   = 2'(i % 4);
         tbl[i].exp_aready = 1'b1;
      end

      reset = 1'b1; paxi_avalid = 1'b0; paxi_atype = 1'b0;
      paxi_aid = '0; paxi_aaddr = '0; paxi_alen = '0; paxi_asize = '0;
      paxi_aburst = '0; paxi_alock = '0;
      axi_arready = 1'b1; axi_awready = 1'b1;

      // Reset state
      step(3);
      @(negedge clk);
      chk("rst_aready", 64'(paxi_aready), 64'd0);
      chk("rst_arvalid", 64'(axi_arvalid), 64'd0);
      chk("rst_awvalid", 64'(axi_awvalid), 64'd0);
      chk("rst_idle", 64'(idle), 64'd1);
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      chk("post_rst_aready", 64'(paxi_aready), 64'd1);
      @(posedge clk); #1;

      // Single read: latency and no AW activity
      send(ATYPE_READ, mk(8'h05, 32'h0000_1000, 8'd7), fr);
      @(negedge clk);
      chk("rd_lat_hold", 64'(axi_arvalid), 64'd0);
      @(negedge clk);
      chk("rd_lat_valid", 64'(axi_arvalid), 64'd1);
      chk("rd_araddr", 64'(axi_araddr), 64'h1000);
      chk("rd_arid", 64'(axi_arid), 64'h05);
      chk("rd_arlen", 64'(axi_arlen), 64'd7);
      wait_drain("rd_drain");
      chk("rd_ar_count", 64'(ar_xfers), 64'd1);
      chk("rd_aw_count", 64'(aw_xfers), 64'd0);
      @(posedge clk); #1;

      // Alternating stream, table driven
      ar0 = ar_xfers; aw0 = aw_xfers;
      for (int i = 0; i < 16; i++) begin
         send(tbl[i].atype, tbl[i].cmd, fr);
         chk($sformatf("stream_aready[%0d]", i), 64'(fr), 64'(tbl[i].exp_aready));
      end
      wait_drain("stream_drain");
      chk("stream_ar_count", 64'(ar_xfers - ar0), 64'd8);
      chk("stream_aw_count", 64'(aw_xfers - aw0), 64'd8);
      @(posedge clk); #1;

      // AW backpressure: 2 writes fill FIFO, 3rd sits in hold, later read is blocked
      axi_awready = 1'b0;
      ar0 = ar_xfers; aw0 = aw_xfers;
      send(ATYPE_WRITE, mk(8'h41, 32'h0000_4100, 8'd1), fr);
      send(ATYPE_WRITE, mk(8'h42, 32'h0000_4200, 8'd2), fr);
      send(ATYPE_WRITE, mk(8'h43, 32'h0000_4300, 8'd3), fr);
      @(negedge clk);
      chk("bp_aready_low", 64'(paxi_aready), 64'd0);
      chk("bp_awvalid", 64'(axi_awvalid), 64'd1);
      chk("bp_idle", 64'(idle), 64'd0);
      @(posedge clk); #1;
      fork
         begin
            logic f;
            send(ATYPE_WRITE, mk(8'h44, 32'h0000_4400, 8'd4), f);
            send(ATYPE_READ,  mk(8'h51, 32'h0000_5100, 8'd5), f);
         end
      join_none
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_read_stalled", 64'(axi_arvalid), 64'd0);
         chk("bp_aready_held", 64'(paxi_aready), 64'd0);
      end
      @(posedge clk); #1;
      axi_awready = 1'b1;
      wait_drain("bp_drain");
      chk("bp_aw_count", 64'(aw_xfers - aw0), 64'd4);
      chk("bp_ar_count", 64'(ar_xfers - ar0), 64'd1);
      @(posedge clk); #1;

      // AR stall for 10 cycles: head stable, then one transfer per cycle
      axi_arready = 1'b0;
      r1 = mk(8'h61, 32'h0000_6100, 8'd9);
      send(ATYPE_READ, r1, fr);
      send(ATYPE_READ, mk(8'h62, 32'h0000_6200, 8'd10), fr);
      send(ATYPE_READ, mk(8'h63, 32'h0000_6300, 8'd11), fr);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("stall_arvalid", 64'(axi_arvalid), 64'd1);
         chk("stall_head", {axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock}, 64'(r1));
      end
      @(posedge clk); #1;
      axi_arready = 1'b1;
      ar0 = ar_xfers;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("release_valid[%0d]", k), 64'(axi_arvalid), 64'd1);
      end
      @(negedge clk);
      chk("release_done", 64'(axi_arvalid), 64'd0);
      chk("release_count", 64'(ar_xfers - ar0), 64'd3);
      wait_drain("release_drain");
      @(posedge clk); #1;

      // Reset with commands queued in both FIFOs
      axi_arready = 1'b0; axi_awready = 1'b0;
      send(ATYPE_WRITE, mk(8'h71, 32'h0000_7100, 8'd1), fr);
      send(ATYPE_WRITE, mk(8'h72, 32'h0000_7200, 8'd2), fr);
      send(ATYPE_READ,  mk(8'h73, 32'h0000_7300, 8'd3), fr);
      step(2);
      ar0 = ar_xfers; aw0 = aw_xfers;
      reset = 1'b1; axi_arready = 1'b1; axi_awready = 1'b1;
      exp_ar.delete(); exp_aw.delete();
      @(negedge clk);
      chk("mrst_arvalid", 64'(axi_arvalid), 64'd0);
      chk("mrst_awvalid", 64'(axi_awvalid), 64'd0);
      chk("mrst_idle", 64'(idle), 64'd1);
      chk("mrst_aready", 64'(paxi_aready), 64'd0);
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      chk("mrst_aready_after", 64'(paxi_aready), 64'd1);
      chk("mrst_idle_after", 64'(idle), 64'd1);
      step(5);
      chk("mrst_no_stale_ar", 64'(ar_xfers - ar0), 64'd0);
      chk("mrst_no_stale_aw", 64'(aw_xfers - aw0), 64'd0);
      send(ATYPE_READ, mk(8'h81, 32'h0000_8100, 8'd4), fr);
      wait_drain("mrst_fresh_drain");
      chk("mrst_fresh_count", 64'(ar_xfers - ar0), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pseudo_axi_splitter.md
PSEUDO_AXI_SPLITTER -- requirements
Module: pseudo_axi_splitter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, per-channel command FIFO depth; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge clocked on clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 paxi_aid/aaddr/alen/asize/aburst/alock  input  8/32/8/3/2/2  combined pseudo-AXI command fields.
REQ-005 paxi_atype  input  1  direction: 0 = read, 1 = write.
REQ-006 paxi_avalid  input  1  command valid.
REQ-007 paxi_aready  output  1  command accepted when high together with paxi_avalid.
REQ-008 axi_arid/araddr/arlen/arsize/arburst/arlock  output  8/32/8/3/2/2  AXI read-address fields.
REQ-009 axi_arvalid output 1, axi_arready input 1  AXI read-address handshake.
REQ-010 axi_awid/awaddr/awlen/awsize/awburst/awlock  output  8/32/8/3/2/2  AXI write-address fields.
REQ-011 axi_awvalid output 1, axi_awready input 1  AXI write-address handshake.
REQ-012 idle  output  1  high when the hold register and both FIFOs are empty.

Function
REQ-013 Transfer on any channel SHALL occur only on a rising clk edge where valid and ready are both high.
REQ-014 An accepted paxi command (55 field bits plus atype) SHALL load a single-entry hold register.
REQ-015 The hold register SHALL move to the AR FIFO when atype=0, or to the AW FIFO when atype=1, in any cycle where that FIFO's registered occupancy is below FIFO_DEPTH.
REQ-016 paxi_aready SHALL be (hold empty OR hold drains this cycle) AND NOT reset.
REQ-017 paxi_aready SHALL have no combinational path from any paxi_* input.
REQ-018 axi_arvalid/axi_awvalid SHALL equal "FIFO non-empty" and be driven from registers.
REQ-019 AR/AW field outputs SHALL present the FIFO head and SHALL remain stable while valid is high and ready is low.
REQ-020 Minimum latency SHALL be 2 cycles: paxi accept at edge N, hold→FIFO at N+1, AXI valid high after N+1.
REQ-021 Sustained throughput SHALL be 1 command/cycle while the destination FIFO is not full.
REQ-022 Commands SHALL be forwarded in acceptance order per channel.
REQ-023 A command waiting in hold for a full FIFO SHALL block later commands of either type (no bypass).
REQ-024 Simultaneous push and pop on a FIFO SHALL leave occupancy unchanged and SHALL be legal at any occupancy below FIFO_DEPTH.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use clog2(FIFO_DEPTH)+1 bits.
REQ-026 Field bits SHALL pass unmodified; atype SHALL NOT be forwarded.

Reset
REQ-027 While reset is high: paxi_aready=0, axi_arvalid=0, axi_awvalid=0, idle=1.
REQ-028 Reset SHALL clear the hold register, both FIFO pointers and both occupancies.
REQ-029 Reset asserted mid-operation SHALL discard all queued commands without emitting them.
REQ-030 The first cycle after reset deasserts SHALL have paxi_aready=1.

Structure
REQ-031 Package pseudo_axi_pkg SHALL hold:
- paxi_cmd_t packed struct (id, addr, len, size, burst, lock; 55 bits);
- ATYPE_READ=1'b0 and ATYPE_WRITE=1'b1.
REQ-032 Sub-module paxi_cmd_fifo (parameter DEPTH, paxi_cmd_t payload, valid/ready on both sides) SHALL be instantiated twice, once for AR and once for AW.

Verification
REQ-033 Single read at addr 0x0000_1000, id 0x05, len 7, both readies high:
- arvalid high 2 cycles after accept with matching fields;
- awvalid never rises.
REQ-034 Alternating R/W stream of 16 commands, all readies high:
- paxi_aready stays 1;
- 8 AR and 8 AW transfers in order, with no field mismatch.
REQ-035 axi_awready=0, 4 writes then 1 read, FIFO_DEPTH=2:
- 2 writes fill the FIFO and 1 sits in hold;
- paxi_aready drops after the 3rd write;
- the read is stalled until awready=1.
REQ-036 AR held off with arvalid=1 and arready=0 for 10 cycles:
- araddr and other fields stable;
- releasing arready yields exactly one transfer per cycle.
REQ-037 Reset pulsed with 3 commands queued:
- valids low the same cycle;
- idle=1;
- no stale command emitted afterward;
- paxi_aready=1 the next cycle.
